mem_port_arbiter: RTL and testbench

//  Shares one single-port unified memory between the IF stage (instruction fetch) and the MEM stage (load/store).

---
 rtl/mem_port_arbiter_if.sv | 41 ++++
 rtl/mem_port_arbiter.sv | 111 +++++++++++
 tb/tb_mem_port_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Request/response bundle between the IF and MEM pipeline stages, the shared memory
// and mem_port_arbiter. The arbiter connects through the slave modport.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_gnt;
  logic              dm_rvalid;
  logic [DATA_W-1:0] dm_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              stall_if;
  logic              stall_mem;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, stall_if, stall_mem
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, stall_if, stall_mem
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and load/store, one access in flight.
// Optional MEM_ARB_STATS_EN adds saturating conflict_cnt / if_stall_cnt outputs.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W          = 32,
  parameter int unsigned DATA_W          = 32,
  parameter int unsigned MEM_LATENCY     = 1,
  parameter int unsigned MAX_DATA_STREAK = 4
) (
  input  logic              clk,
  input  logic              reset,
  mem_port_arbiter_if.slave bus
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [31:0]       conflict_cnt,
  output logic [31:0]       if_stall_cnt
`endif
);
  localparam int unsigned LAT_W = $clog2(MEM_LATENCY + 1);
  localparam int unsigned STK_W = $clog2(MAX_DATA_STREAK + 1);

  typedef enum logic { IDLE, WAIT } state_t;
  typedef enum logic { OWN_IF, OWN_DM } owner_t;

  state_t           r_state;
  owner_t           r_owner;
  logic             r_owner_we;
  logic [LAT_W-1:0] r_lat_cnt;
  logic [STK_W-1:0] r_streak;

  logic w_done, w_slot, w_if_win, w_dm_win;
  logic w_if_rvalid, w_dm_rvalid, w_stall_if, w_stall_mem;

  // Grants are combinational so a request is accepted in the cycle it is seen; the
  // rvalid cycle of the previous access doubles as a grant slot for back-to-back use.
  always_comb begin
    w_done      = (r_state == WAIT) && (r_lat_cnt == LAT_W'(1));
    w_slot      = !reset && ((r_state == IDLE) || w_done);
    w_dm_win    = w_slot && bus.dm_req &&
                  (!bus.if_req || (r_streak != STK_W'(MAX_DATA_STREAK)));
    w_if_win    = w_slot && bus.if_req && !w_dm_win;
    w_if_rvalid = !reset && w_done && (r_owner == OWN_IF);
    w_dm_rvalid = !reset && w_done && (r_owner == OWN_DM);
    w_stall_if  = !reset && ((bus.if_req && !w_if_win) ||
                  ((r_state == WAIT) && (r_owner == OWN_IF) && !w_if_rvalid));
    w_stall_mem = !reset && ((bus.dm_req && !w_dm_win) ||
                  ((r_state == WAIT) && (r_owner == OWN_DM) && !w_dm_rvalid));
  end

  assign bus.if_gnt    = w_if_win;
  assign bus.dm_gnt    = w_dm_win;
  assign bus.mem_en    = w_if_win || w_dm_win;
  assign bus.mem_we    = w_dm_win && bus.dm_we;
  assign bus.mem_addr  = w_dm_win ? bus.dm_addr : (w_if_win ? bus.if_addr : '0);
  assign bus.mem_wdata = w_dm_win ? bus.dm_wdata : '0;
  assign bus.if_rvalid = w_if_rvalid;
  assign bus.dm_rvalid = w_dm_rvalid;
  assign bus.if_rdata  = w_if_rvalid ? bus.mem_rdata : '0;
  assign bus.dm_rdata  = (w_dm_rvalid && !r_owner_we) ? bus.mem_rdata : '0;
  assign bus.stall_if  = w_stall_if;
  assign bus.stall_mem = w_stall_mem;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_owner    <= OWN_IF;
      r_owner_we <= 1'b0;
      r_lat_cnt  <= '0;
      r_streak   <= '0;
    end else begin
      if (w_if_win || w_dm_win) begin
        r_state    <= WAIT;
        r_owner    <= w_dm_win ? OWN_DM : OWN_IF;
        r_owner_we <= w_dm_win && bus.dm_we;
        r_lat_cnt  <= LAT_W'(MEM_LATENCY);
      end else if (w_done) begin
        r_state   <= IDLE;
        r_lat_cnt <= '0;
      end else if (r_state == WAIT) begin
        r_lat_cnt <= r_lat_cnt - 1'b1;
      end

      if (!bus.if_req || w_if_win) begin
        r_streak <= '0;
      end else if (w_dm_win && (r_streak != STK_W'(MAX_DATA_STREAK))) begin
        r_streak <= r_streak + 1'b1;
      end
    end
  end

`ifdef MEM_ARB_STATS_EN
  logic [31:0] r_conflict_cnt;
  logic [31:0] r_if_stall_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_conflict_cnt <= '0;
      r_if_stall_cnt <= '0;
    end else begin
      if ((w_if_win || w_dm_win) && bus.if_req && bus.dm_req && (r_conflict_cnt != '1)) begin
        r_conflict_cnt <= r_conflict_cnt + 32'd1;
      end
      if (w_stall_if && (r_if_stall_cnt != '1)) begin
        r_if_stall_cnt <= r_if_stall_cnt + 32'd1;
      end
    end
  end

  assign conflict_cnt = r_conflict_cnt;
  assign if_stall_cnt = r_if_stall_cnt;
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: instance A (latency 1, streak 4) against a cycle-count reference
// model, instance B (latency 3, streak 2) for reset during an outstanding access.
module tb_mem_port_arbiter;
  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;
  localparam int unsigned LAT_A = 1;
  localparam int unsigned STK_A = 4;
  localparam int unsigned LAT_B = 3;
  localparam int unsigned STK_B = 2;

  logic clk = 1'b0;
  logic reset_a;
  logic reset_b;
  logic mem_load;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus_a ();
  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus_b ();

`ifdef MEM_ARB_STATS_EN
  logic [31:0] conflict_a, if_stall_a, conflict_b, if_stall_b;
`endif

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(LAT_A), .MAX_DATA_STREAK(STK_A)) u_dut_a (
    .clk(clk), .reset(reset_a), .bus(bus_a)
`ifdef MEM_ARB_STATS_EN
    , .conflict_cnt(conflict_a), .if_stall_cnt(if_stall_a)
`endif
  );

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(LAT_B), .MAX_DATA_STREAK(STK_B)) u_dut_b (
    .clk(clk), .reset(reset_b), .bus(bus_b)
`ifdef MEM_ARB_STATS_EN
    , .conflict_cnt(conflict_b), .if_stall_cnt(if_stall_b)
`endif
  );

  function automatic logic [31:0] init_word(input int unsigned i);
    if (i == 0) return 32'h2008_0005;
    return 32'h0A00_0000 | (i * 32'h0000_0101);
  endfunction

  // Behavioural memories; cycles without a read return random junk on mem_rdata.
  logic [31:0] pmem_a [0:63];
  logic [31:0] pmem_b [0:63];
  logic [31:0] rd_a;
  logic [31:0] pipe_b [0:2];

  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 64; i++) pmem_a[i] <= init_word(i);
    end else if (bus_a.mem_en && bus_a.mem_we) begin
      pmem_a[bus_a.mem_addr[7:2]] <= bus_a.mem_wdata;
    end
    rd_a <= (bus_a.mem_en && !bus_a.mem_we) ? pmem_a[bus_a.mem_addr[7:2]] : $urandom;
  end
  assign bus_a.mem_rdata = rd_a;

  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 64; i++) pmem_b[i] <= init_word(i);
    end else if (bus_b.mem_en && bus_b.mem_we) begin
      pmem_b[bus_b.mem_addr[7:2]] <= bus_b.mem_wdata;
    end
    pipe_b[0] <= (bus_b.mem_en && !bus_b.mem_we) ? pmem_b[bus_b.mem_addr[7:2]] : $urandom;
    pipe_b[1] <= pipe_b[0];
    pipe_b[2] <= pipe_b[1];
  end
  assign bus_b.mem_rdata = pipe_b[2];

  int total = 0;
  int bad   = 0;

  // Reference model for instance A: one outstanding access due at an absolute cycle number.
  int unsigned cyc = 0;
  bit          m_busy;
  int unsigned m_due;
  bit          m_own_if;
  logic [31:0] m_data;
  int unsigned m_streak;
  logic [31:0] ref_mem [0:63];
  bit          last_if, last_dm;

  logic        s_if_gnt, s_dm_gnt, s_if_rvalid, s_dm_rvalid, s_mem_en, s_mem_we;
  logic        s_stall_if, s_stall_mem;
  logic [31:0] s_if_rdata, s_dm_rdata, s_mem_addr, s_mem_wdata;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("%s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic snap(input bit use_b);
    if (use_b) begin
      s_if_gnt = bus_b.if_gnt;       s_dm_gnt = bus_b.dm_gnt;
      s_if_rvalid = bus_b.if_rvalid; s_dm_rvalid = bus_b.dm_rvalid;
      s_if_rdata = bus_b.if_rdata;   s_dm_rdata = bus_b.dm_rdata;
      s_mem_en = bus_b.mem_en;       s_mem_we = bus_b.mem_we;
      s_mem_addr = bus_b.mem_addr;   s_mem_wdata = bus_b.mem_wdata;
      s_stall_if = bus_b.stall_if;   s_stall_mem = bus_b.stall_mem;
    end else begin
      s_if_gnt = bus_a.if_gnt;       s_dm_gnt = bus_a.dm_gnt;
      s_if_rvalid = bus_a.if_rvalid; s_dm_rvalid = bus_a.dm_rvalid;
      s_if_rdata = bus_a.if_rdata;   s_dm_rdata = bus_a.dm_rdata;
      s_mem_en = bus_a.mem_en;       s_mem_we = bus_a.mem_we;
      s_mem_addr = bus_a.mem_addr;   s_mem_wdata = bus_a.mem_wdata;
      s_stall_if = bus_a.stall_if;   s_stall_mem = bus_a.stall_mem;
    end
  endtask

  // One clock of instance A: compare every output with the model, then advance the model.
  task automatic step_a();
    bit e_rv, e_slot, e_if, e_dm, e_ifrv, e_dmrv, e_we, e_sti, e_stm;
    logic [31:0] e_addr, e_wd, e_ifrd, e_dmrd;
    @(negedge clk);
    snap(1'b0);
    e_rv = 0; e_if = 0; e_dm = 0; e_ifrv = 0; e_dmrv = 0; e_we = 0; e_sti = 0; e_stm = 0;
    e_addr = '0; e_wd = '0; e_ifrd = '0; e_dmrd = '0;
    if (!reset_a) begin
      e_rv   = m_busy && (m_due == cyc);
      e_slot = !m_busy || e_rv;
      e_dm   = e_slot && bus_a.dm_req && (!bus_a.if_req || (m_streak < STK_A));
      e_if   = e_slot && bus_a.if_req && !e_dm;
      e_ifrv = e_rv && m_own_if;
      e_dmrv = e_rv && !m_own_if;
      e_ifrd = e_ifrv ? m_data : 32'h0;
      e_dmrd = e_dmrv ? m_data : 32'h0;
      e_we   = e_dm && bus_a.dm_we;
      e_addr = e_dm ? bus_a.dm_addr : (e_if ? bus_a.if_addr : 32'h0);
      e_wd   = e_dm ? bus_a.dm_wdata : 32'h0;
      e_sti  = (bus_a.if_req && !e_if) || (m_busy && m_own_if && !e_rv);
      e_stm  = (bus_a.dm_req && !e_dm) || (m_busy && !m_own_if && !e_rv);
    end
    chk("if_gnt", s_if_gnt, e_if);
    chk("dm_gnt", s_dm_gnt, e_dm);
    chk("if_rvalid", s_if_rvalid, e_ifrv);
    chk("dm_rvalid", s_dm_rvalid, e_dmrv);
    chk("if_rdata", s_if_rdata, e_ifrd);
    chk("dm_rdata", s_dm_rdata, e_dmrd);
    chk("mem_en", s_mem_en, e_if || e_dm);
    chk("mem_we", s_mem_we, e_we);
    chk("mem_addr", s_mem_addr, e_addr);
    chk("mem_wdata", s_mem_wdata, e_wd);
    chk("stall_if", s_stall_if, e_sti);
    chk("stall_mem", s_stall_mem, e_stm);
    if (reset_a) begin
      m_busy = 0;
      m_streak = 0;
    end else begin
      if (e_rv) m_busy = 0;
      if (e_if || e_dm) begin
        m_busy   = 1;
        m_due    = cyc + LAT_A;
        m_own_if = e_if;
        m_data   = e_we ? 32'h0 : ref_mem[e_addr[7:2]];
        if (e_we) ref_mem[e_addr[7:2]] = e_wd;
      end
      if (!bus_a.if_req || e_if) m_streak = 0;
      else if (e_dm && (m_streak < STK_A)) m_streak++;
    end
    last_if = e_if;
    last_dm = e_dm;
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic step_b();
    @(negedge clk);
    snap(1'b1);
    @(posedge clk);
    #1;
  endtask

  bit exp_dm_seq [0:5];

  initial begin
    for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
    m_busy = 0; m_due = 0; m_own_if = 0; m_data = '0; m_streak = 0;
    mem_load = 1; reset_a = 1; reset_b = 1;
    bus_a.if_req = 0; bus_a.if_addr = '0; bus_a.dm_req = 0; bus_a.dm_we = 0;
    bus_a.dm_addr = '0; bus_a.dm_wdata = '0;
    bus_b.if_req = 0; bus_b.if_addr = '0; bus_b.dm_req = 0; bus_b.dm_we = 0;
    bus_b.dm_addr = '0; bus_b.dm_wdata = '0;
    step_a();
    mem_load = 0;
    step_a();
    reset_a = 0;

    // T1: lone fetch of address 0
    bus_a.if_req = 1; bus_a.if_addr = 32'h0;
    step_a();
    chk("T1 if_gnt", s_if_gnt, 1'b1);
    bus_a.if_req = 0;
    step_a();
    chk("T1 if_rvalid", s_if_rvalid, 1'b1);
    chk("T1 if_rdata", s_if_rdata, 32'h2008_0005);

    // T2: simultaneous fetch and load; data side first
    bus_a.if_req = 1; bus_a.if_addr = 32'h4;
    bus_a.dm_req = 1; bus_a.dm_we = 0; bus_a.dm_addr = 32'h40;
    step_a();
    chk("T2 dm_gnt", s_dm_gnt, 1'b1);
    chk("T2 if_wait", s_stall_if, 1'b1);
    bus_a.dm_req = 0;
    step_a();
    chk("T2 dm_rvalid", s_dm_rvalid, 1'b1);
    chk("T2 dm_rdata", s_dm_rdata, init_word(16));
    chk("T2 if_gnt", s_if_gnt, 1'b1);
    bus_a.if_req = 0;
    step_a();
    chk("T2 if_rvalid", s_if_rvalid, 1'b1);
    chk("T2 if_rdata", s_if_rdata, init_word(1));

    // T3: both held high; four data grants, then fetch, then data again
    exp_dm_seq = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    bus_a.if_req = 1; bus_a.if_addr = 32'h8;
    bus_a.dm_req = 1; bus_a.dm_we = 0; bus_a.dm_addr = 32'h20;
    for (int i = 0; i < 6; i++) begin
      step_a();
      chk("T3 dm_gnt", s_dm_gnt, exp_dm_seq[i]);
      chk("T3 if_gnt", s_if_gnt, !exp_dm_seq[i]);
    end
    bus_a.if_req = 0; bus_a.dm_req = 0;
    step_a();

    // T4: store then load of the same word
    bus_a.dm_req = 1; bus_a.dm_we = 1; bus_a.dm_addr = 32'h10; bus_a.dm_wdata = 32'hDEAD_BEEF;
    step_a();
    chk("T4 mem_we", s_mem_we, 1'b1);
    chk("T4 mem_addr", s_mem_addr, 32'h10);
    chk("T4 mem_wdata", s_mem_wdata, 32'hDEAD_BEEF);
    bus_a.dm_we = 0; bus_a.dm_wdata = 32'h0;
    step_a();
    chk("T4 store_ack", s_dm_rvalid, 1'b1);
    chk("T4 ack_rdata", s_dm_rdata, 32'h0);
    chk("T4 load_gnt", s_dm_gnt, 1'b1);
    bus_a.dm_req = 0;
    step_a();
    chk("T4 load_rdata", s_dm_rdata, 32'hDEAD_BEEF);

    // Random traffic with occasional abandoned requests and a reset in the middle
    for (int n = 0; n < 600; n++) begin
      if (!bus_a.if_req && ($urandom_range(0, 3) != 0)) begin
        bus_a.if_req = 1;
        bus_a.if_addr = 32'($urandom_range(0, 63)) << 2;
      end else if (bus_a.if_req && ($urandom_range(0, 15) == 0)) begin
        bus_a.if_req = 0;
      end
      if (!bus_a.dm_req && ($urandom_range(0, 2) != 0)) begin
        bus_a.dm_req = 1;
        bus_a.dm_we = 1'($urandom_range(0, 1));
        bus_a.dm_addr = 32'($urandom_range(0, 63)) << 2;
        bus_a.dm_wdata = $urandom;
      end
      if (n == 300) reset_a = 1;
      if (n == 302) reset_a = 0;
      step_a();
      if (last_if) bus_a.if_req = 0;
      if (last_dm) bus_a.dm_req = 0;
    end
    bus_a.if_req = 0; bus_a.dm_req = 0;
    step_a();
    step_a();

`ifdef MEM_ARB_STATS_EN
    // T6: three grant cycles with both ports requesting
    reset_a = 1;
    step_a();
    reset_a = 0;
    bus_a.if_req = 1; bus_a.if_addr = 32'h0;
    bus_a.dm_req = 1; bus_a.dm_we = 0; bus_a.dm_addr = 32'h4;
    for (int i = 0; i < 3; i++) step_a();
    chk("T6 conflict_cnt", conflict_a, 32'd3);
    chk("T6 if_stall_cnt", if_stall_a, 32'd3);
    bus_a.if_req = 0; bus_a.dm_req = 0;
    reset_a = 1;
    step_a();
    reset_a = 0;
    chk("T6 conflict_rst", conflict_a, 32'd0);
    chk("T6 stall_rst", if_stall_a, 32'd0);
`endif

    // T5: latency 3, reset one cycle after the grant drops the access
    step_b();
    reset_b = 0;
    bus_b.dm_req = 1; bus_b.dm_we = 0; bus_b.dm_addr = 32'h8;
    step_b();
    chk("T5 dm_gnt", s_dm_gnt, 1'b1);
    chk("T5 mem_addr", s_mem_addr, 32'h8);
    bus_b.dm_req = 0;
    reset_b = 1;
    step_b();
    chk("T5 rst_outs", {s_if_gnt, s_dm_gnt, s_if_rvalid, s_dm_rvalid, s_mem_en, s_mem_we,
                        s_stall_if, s_stall_mem}, 8'h0);
    chk("T5 rst_bus", {s_mem_addr, s_mem_wdata}, 64'h0);
    reset_b = 0;
    for (int i = 0; i < 4; i++) begin
      step_b();
      chk("T5 no_rvalid", {s_dm_rvalid, s_if_rvalid}, 2'b00);
      chk("T5 no_rdata", {s_dm_rdata, s_if_rdata}, 64'h0);
    end
    bus_b.if_req = 1; bus_b.if_addr = 32'h0;
    step_b();
    chk("T5 if_gnt", s_if_gnt, 1'b1);
    bus_b.if_req = 0;
    for (int i = 0; i < 2; i++) begin
      step_b();
      chk("T5 wait_rvalid", s_if_rvalid, 1'b0);
      chk("T5 wait_stall", s_stall_if, 1'b1);
    end
    step_b();
    chk("T5 if_rvalid", s_if_rvalid, 1'b1);
    chk("T5 if_rdata", s_if_rdata, 32'h2008_0005);
    chk("T5 stall_clr", s_stall_if, 1'b0);
`ifdef MEM_ARB_STATS_EN
    chk("T5 conflict_b", conflict_b, 32'd0);
    chk("T5 if_stall_b", if_stall_b, 32'd2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
